// File: rtl/tb_memory_ws.sv
// Byte-addressed single-port test memory with a request/done handshake and a fixed
// number of wait states per access, used to exercise a CPU's memory-stall path.
module tb_memory_ws #(
  parameter int ADDR_WIDTH   = 16,
  parameter int NUM_BYTES    = 65536,
  parameter int WAIT_STATES  = 2,
  parameter bit ERR_ON_RANGE = 1'b1
) (
  input  logic                  write_clk,
  input  logic                  reset,
  input  logic                  req,
  input  logic                  req_we,
  input  logic                  req_sz,
  input  logic [ADDR_WIDTH-1:0] req_addr,
  input  logic [15:0]           req_wdata,
  output logic                  busy,
  output logic                  done,
  output logic [15:0]           rd_data,
  output logic                  err
);
  localparam int AW1 = ADDR_WIDTH + 1;
  localparam int IW  = (NUM_BYTES > 1) ? $clog2(NUM_BYTES) : 1;
  localparam logic [AW1-1:0] NB = AW1'(NUM_BYTES);
  localparam logic [3:0]     WS = 4'(WAIT_STATES);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_XFER = 2'd2
  } state_t;

  // Contents are loaded hierarchically by the bench and survive reset.
  logic [7:0] mem [0:NUM_BYTES-1];

  state_t                state_r, state_next_s;
  logic [3:0]            cnt_r;
  logic                  we_r, sz_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [15:0]           wdata_r;
  logic                  busy_r, done_r, err_r;
  logic [15:0]           rd_data_r;
  logic                  busy_next_s, done_next_s, err_next_s;
  logic [15:0]           rd_next_s;

  logic [AW1-1:0] addr_lo_s, addr_hi_s;
  logic [IW-1:0]  idx0_s, idx1_s;
  logic           oor_s, range_err_s;
  logic [15:0]    rd_value_s;

  // Address decode: array indices always wrap, so the array is never indexed out of bounds;
  // in error mode an out-of-range access is suppressed instead of using the wrapped index.
  always_comb begin
    addr_lo_s   = {1'b0, addr_r};
    addr_hi_s   = addr_lo_s + AW1'(1);
    idx0_s      = IW'(addr_lo_s % NB);
    idx1_s      = IW'(addr_hi_s % NB);
    oor_s       = (addr_lo_s >= NB) || (sz_r && (addr_hi_s >= NB));
    range_err_s = ERR_ON_RANGE && oor_s;
    if (range_err_s) begin
      rd_value_s = 16'hDEAD;
    end else if (sz_r) begin
      rd_value_s = {mem[idx0_s], mem[idx1_s]};
    end else begin
      rd_value_s = {8'h00, mem[idx0_s]};
    end
  end

  // State register, wait counter and latched request.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
      cnt_r   <= 4'd0;
      we_r    <= 1'b0;
      sz_r    <= 1'b0;
      addr_r  <= '0;
      wdata_r <= 16'h0000;
    end else begin
      state_r <= state_next_s;
      case (state_r)
        ST_IDLE: begin
          if (req) begin
            cnt_r   <= WS;
            we_r    <= req_we;
            sz_r    <= req_sz;
            addr_r  <= req_addr;
            wdata_r <= req_wdata;
          end
        end
        ST_WAIT: cnt_r <= cnt_r - 4'd1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end

  // Next-state decode.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          state_next_s = (WS != 4'd0) ? ST_WAIT : ST_XFER;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_r <= 4'd1) begin
          state_next_s = ST_XFER;
        end else begin
          state_next_s = ST_WAIT;
        end
      end
      ST_XFER: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Next values of the registered outputs.
  always_comb begin
    busy_next_s = busy_r;
    done_next_s = 1'b0;
    err_next_s  = 1'b0;
    rd_next_s   = rd_data_r;
    case (state_r)
      ST_IDLE: begin
        if (req) begin
          busy_next_s = 1'b1;
        end else begin
          busy_next_s = 1'b0;
        end
      end
      ST_WAIT: busy_next_s = 1'b1;
      ST_XFER: begin
        busy_next_s = 1'b0;
        done_next_s = 1'b1;
        err_next_s  = range_err_s;
        if (!we_r) begin
          rd_next_s = rd_value_s;
        end else begin
          rd_next_s = rd_data_r;
        end
      end
      default: busy_next_s = 1'b0;
    endcase
  end

  // Output registers.
  always_ff @(posedge write_clk) begin
    if (reset) begin
      busy_r    <= 1'b0;
      done_r    <= 1'b0;
      err_r     <= 1'b0;
      rd_data_r <= 16'h0000;
    end else begin
      busy_r    <= busy_next_s;
      done_r    <= done_next_s;
      err_r     <= err_next_s;
      rd_data_r <= rd_next_s;
    end
  end

  // Memory write on the transfer edge only; an aborting reset blocks it.
  always_ff @(posedge write_clk) begin
    if (!reset && (state_r == ST_XFER) && we_r && !range_err_s) begin
      if (sz_r) begin
        mem[idx0_s] <= wdata_r[15:8];
        mem[idx1_s] <= wdata_r[7:0];
      end else begin
        mem[idx0_s] <= wdata_r[7:0];
      end
    end
  end

  assign busy    = busy_r;
  assign done    = done_r;
  assign err     = err_r;
  assign rd_data = rd_data_r;

endmodule

// File: doc/tb_memory_ws.md
Name: tb_memory_ws

Overview:
- Parametrised successor to the bench test memory.
- Single-port byte-addressed memory for CPU testbenches, with a request/done handshake and a programmable wait-state counter, so the CPU's memory-stall path can be exercised.
- Supports 8-bit and 16-bit accesses, big-endian: the byte at addr is the high byte.
- Reads are registered (no asynchronous path).
- Contents are preloaded by the bench through hierarchical init; reset never clears them.

Parameters:
- ADDR_WIDTH, 16, width of the byte address.
- NUM_BYTES, 65536, memory depth in bytes; must be ≤ 2**ADDR_WIDTH.
- WAIT_STATES, 2, extra stall cycles per access, 0..15.
- ERR_ON_RANGE, 1, if 1 flag out-of-range accesses; if 0 wrap the address modulo NUM_BYTES.

Ports:
- write_clk  input  1  clock; all state changes on its rising edge.
- reset  input  1  synchronous, active-high.
- req  input  1  access request; sampled only when busy=0.
- req_we  input  1  1=write, 0=read.
- req_sz  input  1  0=8-bit (cpu_data_acc_sz_8), 1=16-bit.
- req_addr  input  ADDR_WIDTH  byte address.
- req_wdata  input  16  write data; [7:0] only for 8-bit.
- busy  output  1  access in progress; new req ignored.
- done  output  1  one-cycle pulse on access completion.
- rd_data  output  16  read result, valid when done=1 and the access was a read; 8-bit reads zero-extend.
- err  output  1  one-cycle pulse with done when the access was out of range.

Behaviour:
- Reset (synchronous, active-high): state=IDLE, busy=0, done=0, err=0, rd_data=16'h0000, wait counter=0. Memory array is untouched.
- States: IDLE, WAIT, XFER.
- IDLE, req=1 at edge:
  - latch we, sz, addr, wdata; busy=1 from the next cycle.
  - counter=WAIT_STATES.
  - next state WAIT if WAIT_STATES>0, else XFER.
- WAIT: counter decrements each edge; at counter==1 go to XFER.
- XFER edge:
  - perform the access; assert done (and err if applicable) for exactly one cycle; busy=0; return to IDLE.
- Latency: req edge to done high is WAIT_STATES+1 cycles. Back-to-back: a req sampled in the cycle done is high is accepted, giving one access every WAIT_STATES+2 cycles.
- Write:
  - 8-bit: mem[a]=wdata[7:0].
  - 16-bit: mem[a]=wdata[15:8], mem[a+1]=wdata[7:0].
  - Writes occur only on the XFER edge.
- Read:
  - 8-bit: rd_data={8'h00, mem[a]}.
  - 16-bit: rd_data={mem[a], mem[a+1]}.
  - rd_data holds its value until the next read completes; writes do not alter it.
- Range:
  - An access is out of range if a ≥ NUM_BYTES, or if it is 16-bit and a+1 ≥ NUM_BYTES.
  - ERR_ON_RANGE=1: out-of-range write is dropped entirely; out-of-range read returns 16'hDEAD; err=1 with done.
  - ERR_ON_RANGE=0: each byte address is taken modulo NUM_BYTES (a 16-bit access at NUM_BYTES-1 pairs with byte 0); err stays 0.
- Unaligned 16-bit accesses are legal.
- req while busy=1 is ignored, not queued.
- Request inputs may change freely after acceptance; the latched copy is used.
- Reset mid-access: access aborted, no memory write, no done pulse.
- reset and req in the same cycle: reset wins; the req is dropped.

Test Plan:
- WAIT_STATES=2, after reset: busy=0, done=0, rd_data=0. 16-bit write addr=16'h0010, wdata=16'hA55A at edge T → busy at T+1..T+2, done at T+3. Then 8-bit reads of 0x10 and 0x11 → 16'h00A5 and 16'h005A.
- WAIT_STATES=0: 16-bit read of preloaded mem[4]=8'h31, mem[5]=8'hC2 → done one cycle after req, rd_data=16'h31C2. Back-to-back reqs → done every 2 cycles.
- Hold req high for the whole access with a changing addr → exactly one access performed, using the address latched at acceptance.
- NUM_BYTES=256, ERR_ON_RANGE=1: 16-bit write to 8'hFF → done+err, mem[0xFF] and mem[0x00] unchanged; read of 0x100 → rd_data=16'hDEAD, err=1.
- NUM_BYTES=256, ERR_ON_RANGE=0: 16-bit write 16'h1234 to 0xFF → mem[0xFF]=8'h12, mem[0x00]=8'h34, err=0.
- WAIT_STATES=3: assert reset one cycle after a write req → no done pulse, target byte keeps its old value, busy=0 after the reset edge.
